// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: ID-stage decode info and EX/MEM
// status in, operand forwarding selects and pipeline stall/flush controls out.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              id_use_rs1, id_use_rs2;
  logic              id_regwrite, id_memread;
  logic              ex_branch_taken;
  logic              mem_wait;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall_if, stall_id;
  logic              flush_id, flush_ex;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_regwrite, id_memread, ex_branch_taken, mem_wait,
    input  fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
           id_regwrite, id_memread, ex_branch_taken, mem_wait,
    output fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Forwarding / load-use stall / branch flush control for the 5-stage RV32I core.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave hz
);

  logic              ex_valid, ex_regwrite, ex_memread;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic              mem_valid, mem_regwrite;
  logic [REG_AW-1:0] mem_rd;
  logic              wb_valid, wb_regwrite;
  logic [REG_AW-1:0] wb_rd;

  logic mem_wr, wb_wr, load_use;
  logic stall, fl_id, fl_ex;

  // x0 is hardwired zero, so a stage targeting it never counts as writing
  assign mem_wr = mem_valid && mem_regwrite && (mem_rd != '0);
  assign wb_wr  = wb_valid  && wb_regwrite  && (wb_rd  != '0);

  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && hz.id_valid &&
                    ((hz.id_use_rs1 && (hz.id_rs1 == ex_rd)) ||
                     (hz.id_use_rs2 && (hz.id_rs2 == ex_rd)));

  function automatic logic [1:0] fsel(
    input logic              ev,
    input logic              mw,
    input logic              ww,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] mrd,
    input logic [REG_AW-1:0] wrd
  );
    if (!ev)              return 2'b00;
    if (mw && (mrd == rs)) return 2'b10;
    if (ww && (wrd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign hz.fwd_a = fsel(ex_valid, mem_wr, wb_wr, ex_rs1, mem_rd, wb_rd);
  assign hz.fwd_b = fsel(ex_valid, mem_wr, wb_wr, ex_rs2, mem_rd, wb_rd);

  // A taken branch squashes the dependent instruction, so it outranks load-use
  always_comb begin
    stall = 1'b0;
    fl_id = 1'b0;
    fl_ex = 1'b0;
    if (!reset) begin
      if (hz.mem_wait) begin
        stall = 1'b1;
      end else if (hz.ex_branch_taken) begin
        fl_id = 1'b1;
        fl_ex = 1'b1;
      end else if (load_use) begin
        stall = 1'b1;
        fl_ex = 1'b1;
      end
    end
  end

  assign hz.stall_if = stall;
  assign hz.stall_id = stall;
  assign hz.flush_id = fl_id;
  assign hz.flush_ex = fl_ex;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid     <= 1'b0;
      ex_regwrite  <= 1'b0;
      ex_memread   <= 1'b0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      mem_valid    <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
    end else if (!hz.mem_wait) begin
      if (fl_ex) begin
        ex_valid    <= 1'b0;
        ex_regwrite <= 1'b0;
        ex_memread  <= 1'b0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rd       <= '0;
      end else begin
        ex_valid    <= hz.id_valid;
        ex_regwrite <= hz.id_regwrite;
        ex_memread  <= hz.id_memread;
        ex_rs1      <= hz.id_rs1;
        ex_rs2      <= hz.id_rs2;
        ex_rd       <= hz.id_rd;
      end
      mem_valid    <= ex_valid;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall_take;

  // Counts only stalls actually taken; a branch in the same cycle wins
  assign stall_take = load_use && !hz.ex_branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!hz.mem_wait) begin
      if (stall_take && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (hz.ex_branch_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core. It shadows the destination-register, regwrite and memread state of the EX, MEM and WB stages in its own stage registers. From that state it drives the 2-bit select inputs of both ALU-operand 3:1 muxes (forwarding), and asserts the load-use stall and branch flush controls for the IF/ID and ID/EX pipeline registers. It sits beside the datapath and is instantiated once, in the top-level core.

## Interface
Parameters:
- REG_AW, 5, register-index width.
- CNT_W, 32, width of the performance counters (see Configuration).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all stage state.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers of the ID instruction.
- id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1 / rs2.
- id_rd  in  REG_AW  destination of the ID instruction.
- id_regwrite, id_memread  in  1  ID instruction writes the regfile / is a load.
- ex_branch_taken  in  1  branch or jump resolved taken in EX this cycle.
- mem_wait  in  1  data memory not ready; freezes the whole pipeline.
- fwd_a, fwd_b  out  2  operand mux selects: 00 = regfile, 01 = WB result, 10 = MEM ALU result.
- stall_if, stall_id  out  1  hold PC and IF/ID.
- flush_id, flush_ex  out  1  IF/ID and ID/EX load a bubble.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

## Operation
- Stage registers: ex_{valid,rs1,rs2,rd,regwrite,memread}, mem_{valid,rd,regwrite}, wb_{valid,rd,regwrite}.
- A stage is "writing" when valid && regwrite && rd != 0. Register x0 is never forwarded and never causes a stall.
- Forwarding (combinational from the stage registers), per operand, for the EX instruction's rs1 (fwd_a) and rs2 (fwd_b):
  - 10 if MEM is writing and mem_rd matches.
  - Else 01 if WB is writing and wb_rd matches.
  - Else 00.
  - MEM has priority over WB. The selects are 00 whenever ex_valid = 0.
- Load-use condition: ex_valid && ex_memread && ex_rd != 0 && id_valid && ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd)).
  - When true: stall_if = stall_id = flush_ex = 1 for exactly one cycle.
- Branch: ex_branch_taken forces flush_id = flush_ex = 1 and stall_if = stall_id = 0.
  - Flush has priority over load-use, because the dependent instruction is squashed anyway.
- Stage advance each edge, when not frozen:
  - EX ← ID fields, or a bubble (valid = 0, regwrite = 0, memread = 0) if flush_ex.
  - MEM ← EX.
  - WB ← MEM.
- Freeze: while mem_wait = 1, all stage registers and counters hold. stall_if = stall_id = 1, flush outputs = 0, and fwd_* are still driven from the held state.
- Priority: reset > mem_wait > ex_branch_taken > load-use.

## Timing
- Reset: all stage valid and regwrite bits = 0 and all rd = 0, so fwd_a = fwd_b = 00, all stall and flush outputs = 0, and counters = 0. Outputs hold these values from the first edge with reset = 1.
- Reset asserted mid-stall or mid-freeze clears state on that edge. The first cycle after reset has no hazards.
- fwd_*, stall_*, flush_* are combinational from the current stage registers plus the ID inputs and control inputs. There is no registered output latency.
- A load followed directly by a dependent instruction costs exactly one bubble. The dependent instruction then sees fwd = 01 (load in WB).
- Back-to-back ALU dependence costs zero bubbles (fwd = 10).
- A load-use and mem_wait arriving together: freeze first. The stall is taken once the pipeline resumes.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cnt increments once per load-use stall cycle.
  - flush_cnt increments once per cycle with ex_branch_taken.
  - Both counters are frozen while mem_wait = 1, saturate at 2^CNT_W − 1, and clear on reset.
- HAZARD_PERF_EN undefined: the counters are not built, and both ports are constant 0.

## Test plan
- After reset, issue add x5 then sub x6,x5,x1 -> sub in EX with fwd_a = 10, no stall.
- add x5, nop, and x7,x1,x5 -> fwd_b = 01 when and is in EX.
- add x5 in MEM and add x5 in WB both writing, with EX reading x5 -> fwd_a = 10 (MEM priority).
- lw x8 in EX, ID reads x8 -> stall_if, stall_id and flush_ex high for 1 cycle, then fwd = 01. Writes to x0 never forward or stall. With HAZARD_PERF_EN, stall_cnt = 1.
- ex_branch_taken together with a load-use -> flush_id = flush_ex = 1, stall = 0. flush_cnt increments by 1.
- mem_wait held 3 cycles during a forwarding case -> state and fwd values hold, stall_if = 1. Reset asserted in cycle 2 -> all outputs 0 on the next cycle.
